// File: rtl/led_pattern_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_driver
// Purpose  : LED pin driver behind the LED PIO. Adds global PWM brightness
//            and per-LED blinking, configured over an Avalon-MM slave.
//            With EN clear it is a one-cycle registered pass-through.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_driver #(
    parameter int LED_WIDTH = 10,
    parameter int PRESC_DIV = 50,
    parameter int BLINK_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [LED_WIDTH-1:0] led_in,
    output logic [LED_WIDTH-1:0] led_out
);

    localparam logic [15:0]        c_presc_max = 16'(PRESC_DIV - 1);
    localparam logic [BLINK_W-1:0] c_half_one  = BLINK_W'(1);

    logic                 r_en;
    logic [LED_WIDTH-1:0] r_blink_mask;
    logic [7:0]           r_duty;
    logic [BLINK_W-1:0]   r_half;
    logic [15:0]          r_presc_cnt;
    logic                 r_tick;
    logic [7:0]           r_pwm_cnt;
    logic [BLINK_W-1:0]   r_blink_cnt;
    logic                 r_blink_phase;

    logic                 w_wr;
    logic                 w_pwm_on;
    logic                 w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_pwm_on       = (r_duty == 8'hFF) | (r_pwm_cnt < r_duty);
    // Only a subset of the write bus maps onto register fields.
    assign w_unused_wdata = ^writedata;

    // Configuration registers; STATUS (address 3) is read-only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en         <= 1'b0;
            r_blink_mask <= '0;
            r_duty       <= 8'hFF;
            r_half       <= '0;
        end else if (w_wr) begin
            case (address)
                2'd0: begin
                    r_en         <= writedata[0];
                    r_blink_mask <= writedata[16 +: LED_WIDTH];
                end
                2'd1:    r_duty <= writedata[7:0];
                2'd2:    r_half <= writedata[BLINK_W-1:0];
                default: ;
            endcase
        end
    end

    // Prescaler: tick pulses for one cycle after the counter reaches its top.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc_cnt <= '0;
            r_tick      <= 1'b0;
        end else if (r_presc_cnt == c_presc_max) begin
            r_presc_cnt <= '0;
            r_tick      <= 1'b1;
        end else begin
            r_presc_cnt <= r_presc_cnt + 16'd1;
            r_tick      <= 1'b0;
        end
    end

    // Free-running 8-bit PWM phase counter, advanced once per tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt <= '0;
        end else if (r_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // Blink timer; a HALF write restarts it so the count never overruns HALF.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if ((w_wr && (address == 2'd2)) || (r_half == '0)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (r_tick) begin
            if (r_blink_cnt == (r_half - c_half_one)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + c_half_one;
            end
        end
    end

    // Registered pin drive: pass-through when disabled, gated when enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= '0;
        end else if (!r_en) begin
            led_out <= led_in;
        end else begin
            led_out <= led_in & {LED_WIDTH{w_pwm_on}}
                     & (~r_blink_mask | {LED_WIDTH{r_blink_phase}});
        end
    end

    // Combinational read mux; unused bits read as zero.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0: begin
                readdata[0]                = r_en;
                readdata[16 +: LED_WIDTH]  = r_blink_mask;
            end
            2'd1: readdata[7:0]         = r_duty;
            2'd2: readdata[BLINK_W-1:0] = r_half;
            default: begin
                readdata[15:8] = r_pwm_cnt;
                readdata[0]    = r_blink_phase;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_driver
// Purpose  : Directed self-checking bench for led_pattern_driver
//            (PRESC_DIV=4, so one tick every 4 clocks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  led_in;
    logic [9:0]  led_out;

    int n_cmp = 0;
    int n_bad = 0;

    led_pattern_driver #(
        .LED_WIDTH (10),
        .PRESC_DIV (4),
        .BLINK_W   (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_in     (led_in),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the write lands on the following posedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Length of the current run of led_out[1:0]==val, sampled on negedges.
    task automatic measure_run(input logic [1:0] val, output int len);
        len = 0;
        while ((led_out[1:0] === val) && (len < 100)) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; led_in = 10'h2A5;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (led_out !== 10'h000) begin
            n_bad++; $display("FAIL reset_hold: got %h want %h", led_out, 10'h000);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (led_out !== 10'h2A5) begin
            n_bad++; $display("FAIL reset_passthru: got %h want %h", led_out, 10'h2A5);
        end
        address = 2'd1; #1;
        n_cmp++;
        if (readdata !== 32'h0000_00FF) begin
            n_bad++; $display("FAIL reset_duty: got %h want %h", readdata, 32'h0000_00FF);
        end
        address = 2'd2; #1;
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_half: got %h want %h", readdata, 32'h0);
        end
        address = 2'd0; #1;
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_ctrl: got %h want %h", readdata, 32'h0);
        end
    endtask

    task automatic test_pwm;
        int n_on, n_off, n_other;
        @(negedge clk);
        led_in = 10'h3FF;
        bus_write(2'd1, 32'h40);
        bus_write(2'd0, 32'h1);
        @(negedge clk);
        n_on = 0; n_off = 0; n_other = 0;
        for (int i = 0; i < 1024; i++) begin
            if (led_out === 10'h3FF) n_on++;
            else if (led_out === 10'h000) n_off++;
            else n_other++;
            @(negedge clk);
        end
        n_cmp++;
        if (n_on !== 256) begin
            n_bad++; $display("FAIL pwm40_on_cycles: got %0d want %0d", n_on, 256);
        end
        n_cmp++;
        if (n_off !== 768) begin
            n_bad++; $display("FAIL pwm40_off_cycles: got %0d want %0d (other %0d)", n_off, 768, n_other);
        end
        bus_write(2'd1, 32'h0);
        @(negedge clk);
        n_on = 0;
        for (int i = 0; i < 300; i++) begin
            if (led_out !== 10'h000) n_on++;
            @(negedge clk);
        end
        n_cmp++;
        if (n_on !== 0) begin
            n_bad++; $display("FAIL pwm00_off: got %0d nonzero cycles want 0", n_on);
        end
        bus_write(2'd1, 32'hFF);
        @(negedge clk);
        n_off = 0;
        for (int i = 0; i < 300; i++) begin
            if (led_out !== 10'h3FF) n_off++;
            @(negedge clk);
        end
        n_cmp++;
        if (n_off !== 0) begin
            n_bad++; $display("FAIL pwmFF_on: got %0d non-full cycles want 0", n_off);
        end
    endtask

    task automatic test_blink;
        int len;
        int hi_bad;
        bus_write(2'd0, 32'h0003_0001);
        bus_write(2'd2, 32'd3);
        address = 2'd3;
        len = 0;
        while ((led_out[1:0] !== 2'b00) && (len < 100)) begin
            len++;
            @(negedge clk);
        end
        n_cmp++;
        if (led_out[1:0] !== 2'b00) begin
            n_bad++; $display("FAIL blink_first_off: got %b want %b", led_out[1:0], 2'b00);
        end
        n_cmp++;
        if (readdata[0] !== 1'b0) begin
            n_bad++; $display("FAIL status_phase0: got %b want %b", readdata[0], 1'b0);
        end
        hi_bad = (led_out[9:2] !== 8'hFF) ? 1 : 0;
        measure_run(2'b00, len);
        n_cmp++;
        if (len !== 12) begin
            n_bad++; $display("FAIL blink_off_run: got %0d want %0d", len, 12);
        end
        n_cmp++;
        if (readdata[0] !== 1'b1) begin
            n_bad++; $display("FAIL status_phase1: got %b want %b", readdata[0], 1'b1);
        end
        if (led_out[9:2] !== 8'hFF) hi_bad++;
        measure_run(2'b11, len);
        n_cmp++;
        if (len !== 12) begin
            n_bad++; $display("FAIL blink_on_run: got %0d want %0d", len, 12);
        end
        n_cmp++;
        if (hi_bad !== 0 || led_out[9:2] !== 8'hFF) begin
            n_bad++; $display("FAIL unmasked_steady: got %h want %h", led_out[9:2], 8'hFF);
        end
    endtask

    task automatic test_half_rewrite;
        int len;
        int n_off;
        // Phase is 0 here: an off run has just begun.
        bus_write(2'd2, 32'd5);
        address = 2'd3; #1;
        n_cmp++;
        if (readdata[0] !== 1'b1) begin
            n_bad++; $display("FAIL half_write_phase: got %b want %b", readdata[0], 1'b1);
        end
        @(negedge clk);
        measure_run(2'b11, len);
        n_cmp++;
        if (len !== 18) begin
            n_bad++; $display("FAIL half5_first_on: got %0d want %0d", len, 18);
        end
        measure_run(2'b00, len);
        n_cmp++;
        if (len !== 20) begin
            n_bad++; $display("FAIL half5_off_run: got %0d want %0d", len, 20);
        end
        bus_write(2'd2, 32'd0);
        @(negedge clk);
        n_off = 0;
        for (int i = 0; i < 60; i++) begin
            if (led_out !== 10'h3FF) n_off++;
            @(negedge clk);
        end
        n_cmp++;
        if (n_off !== 0) begin
            n_bad++; $display("FAIL half0_steady: got %0d dark cycles want 0", n_off);
        end
    endtask

    task automatic test_status_write_and_reset;
        bus_write(2'd2, 32'd3);
        bus_write(2'd3, 32'hFFFF_FFFF);
        address = 2'd0; #1;
        n_cmp++;
        if (readdata !== 32'h0003_0001) begin
            n_bad++; $display("FAIL ro_ctrl: got %h want %h", readdata, 32'h0003_0001);
        end
        address = 2'd1; #1;
        n_cmp++;
        if (readdata !== 32'h0000_00FF) begin
            n_bad++; $display("FAIL ro_duty: got %h want %h", readdata, 32'h0000_00FF);
        end
        address = 2'd2; #1;
        n_cmp++;
        if (readdata !== 32'h0000_0003) begin
            n_bad++; $display("FAIL ro_half: got %h want %h", readdata, 32'h0000_0003);
        end
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (led_out !== 10'h000) begin
            n_bad++; $display("FAIL async_reset_out: got %h want %h", led_out, 10'h000);
        end
        @(negedge clk);
        address = 2'd0; #1;
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_bad++; $display("FAIL rst_ctrl: got %h want %h", readdata, 32'h0);
        end
        address = 2'd1; #1;
        n_cmp++;
        if (readdata !== 32'h0000_00FF) begin
            n_bad++; $display("FAIL rst_duty: got %h want %h", readdata, 32'h0000_00FF);
        end
        address = 2'd2; #1;
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_bad++; $display("FAIL rst_half: got %h want %h", readdata, 32'h0);
        end
        address = 2'd3; #1;
        n_cmp++;
        if (readdata !== 32'h0000_0001) begin
            n_bad++; $display("FAIL rst_status: got %h want %h", readdata, 32'h0000_0001);
        end
        reset_n = 1'b1;
        led_in  = 10'h155;
        @(negedge clk);
        n_cmp++;
        if (led_out !== 10'h155) begin
            n_bad++; $display("FAIL post_rst_passthru: got %h want %h", led_out, 10'h155);
        end
        led_in = 10'h0AA;
        @(negedge clk);
        n_cmp++;
        if (led_out !== 10'h0AA) begin
            n_bad++; $display("FAIL post_rst_latency: got %h want %h", led_out, 10'h0AA);
        end
    endtask

    initial begin
        test_reset();
        test_pwm();
        test_blink();
        test_half_rewrite();
        test_status_write_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
